// File: rtl/rv_pipeline_pkg.sv
// rtl/rv_pipeline_pkg.sv - shared pipeline constants and fetch state encoding
package rv_pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one outstanding request, stall buffer and redirect flush
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);
    import rv_pipeline_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         req;
    logic [31:0]  addr;
    logic [31:0]  pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            pc_out_q    <= 32'h0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        req         = 1'b0;
        addr        = pc_q;

        if (redirect_i) begin
            // A response arriving with the redirect is already consumed, so no DROP needed.
            pc_d        = redirect_pc_i & ~32'h3;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            buf_pc_d    = 32'h0;
            buf_instr_d = NOP_INSTR;
            if ((state_q == FETCH_WAIT || state_q == FETCH_DROP) && !imem_rvalid_i)
                state_d = FETCH_DROP;
            else
                state_d = FETCH_IDLE;
        end else begin
            unique case (state_q)
                FETCH_IDLE: begin
                    req     = 1'b1;
                    addr    = pc_q;
                    state_d = FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid_i && !stall_i) begin
                        pc_out_d = pc_q;
                        instr_d  = imem_rdata_i;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
                        req      = 1'b1;
                        addr     = pc_inc;
                    end else if (imem_rvalid_i) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata_i;
                        state_d     = FETCH_HOLD;
                    end else if (!stall_i) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall_i) begin
                        pc_out_d = buf_pc_q;
                        instr_d  = buf_instr_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
                        req      = 1'b1;
                        addr     = pc_inc;
                        state_d  = FETCH_WAIT;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rvalid_i)
                        state_d = FETCH_IDLE;
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    // Held low during reset even though IDLE would otherwise request.
    assign imem_req_o  = req & rst_ni;
    assign imem_addr_o = addr;
    assign pc_o        = pc_out_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock and one asynchronous, active-low reset.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset (bits[1:0] SHALL be 0).
REQ-003 clk_i  input  1  clock; all state updates on posedge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 stall_i  input  1  downstream hold; pc_o/instr_o/valid_o frozen while 1.
REQ-006 redirect_i  input  1  taken branch/jump from EX; flush and refetch.
REQ-007 redirect_pc_i  input  32  redirect target.
REQ-008 imem_req_o  output  1  one-cycle request strobe to instruction memory.
REQ-009 imem_addr_o  output  32  request address; valid only when imem_req_o=1.
REQ-010 imem_rvalid_i  input  1  response strobe, 1 cycle wide, at least 1 cycle after request.
REQ-011 imem_rdata_i  input  32  instruction word; valid with imem_rvalid_i.
REQ-012 pc_o  output  32  PC of delivered instruction, registered.
REQ-013 instr_o  output  32  delivered instruction, registered; NOP 32'h00000013 when valid_o=0.
REQ-014 valid_o  output  1  instr_o/pc_o hold a real fetched instruction.

Function
REQ-015 SHALL keep at most one request outstanding.
REQ-016 FSM states: IDLE (no request outstanding, none buffered), WAIT (request outstanding), HOLD (response buffered, stalled), DROP (outstanding response to be discarded).
REQ-017 IDLE: assert imem_req_o with imem_addr_o=pc; next state WAIT.
REQ-018 WAIT, imem_rvalid_i=1, stall_i=0: load outputs {pc, imem_rdata_i, 1}; pc<=pc+4; same cycle issue request at pc+4; stay WAIT.
REQ-019 WAIT, imem_rvalid_i=1, stall_i=1: capture pc/rdata into one-entry buffer; no request; next HOLD.
REQ-020 WAIT, imem_rvalid_i=0, stall_i=0: outputs load bubble {pc_o unchanged, NOP, 0}.
REQ-021 HOLD, stall_i=0: move buffer to outputs with valid_o=1; pc<=pc+4; issue request at pc+4; next WAIT.
REQ-022 Any state, stall_i=1 and no redirect: pc_o/instr_o/valid_o unchanged.
REQ-023 Redirect has priority over stall and response: pc<={redirect_pc_i[31:2],2'b00}; outputs <= {pc_o unchanged, NOP, 0}; buffer cleared.
REQ-024 Redirect next state: DROP if request outstanding and imem_rvalid_i=0 this cycle; otherwise IDLE (simultaneous response discarded).
REQ-025 DROP: no request; on imem_rvalid_i response discarded, next IDLE; further redirect updates pc, stays DROP.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-027 imem_rvalid_i in IDLE or HOLD SHALL be ignored.
REQ-028 Latency: request-to-output one cycle after imem_rvalid_i; sustained 1 instr/cycle with 1-cycle memory.

Reset
REQ-029 Reset asserted: state IDLE, pc=RESET_PC, pc_o=0, instr_o=32'h00000013, valid_o=0, buffer cleared, imem_req_o=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding request; first request issued the first clock after deassertion at RESET_PC.

Structure
REQ-031 NOP constant 32'h00000013 and fetch state enum SHALL live in shared package rv_pipeline_pkg.
REQ-032 Flat implementation, no sub-modules; imem_req_o/imem_addr_o combinational from state, pc, inputs.

Verification
REQ-033 Reset release, 1-cycle memory returning addr-tagged words -> requests at 0,4,8; valid_o=1 with pc_o 0,4,8 on consecutive cycles.
REQ-034 stall_i=1 for 3 cycles while response for pc 8 arrives -> outputs hold pc_o=4; on release pc_o=8 valid_o=1, next request at 12, no instruction lost or duplicated.
REQ-035 redirect_i=1, redirect_pc_i=32'h100 with request outstanding -> valid_o=0, instr_o=NOP; late response discarded; next request at 32'h100.
REQ-036 redirect_i and imem_rvalid_i same cycle -> response dropped, next cycle request at target, no DROP state.
REQ-037 redirect_pc_i=32'h103 -> request address 32'h100; RESET_PC=32'hFFFF_FFFC -> second request address 32'h0.
REQ-038 rst_ni pulsed low during WAIT -> outputs reset values immediately (asynchronous); stale imem_rvalid_i during reset ignored; fetch restarts at RESET_PC.
